// File: rtl/approx_pkg.sv
// Shared constants and arithmetic helpers for the approximate Brent-Kung adder
// and the checker that characterises it.
package approx_pkg;

  localparam int APPROX_W = 16;
  localparam int APPROX_K = 4;

  function automatic logic [APPROX_W:0] exact_add(input logic [APPROX_W-1:0] a,
                                                  input logic [APPROX_W-1:0] b,
                                                  input logic cin);
    return {1'b0, a} + {1'b0, b} + {{APPROX_W{1'b0}}, cin};
  endfunction

  // Bits 1..K take the neighbour's generate as carry, G[K] carries into bit K+1,
  // and cin is not used.
  function automatic logic [APPROX_W:0] approx_add(input logic [APPROX_W-1:0] a,
                                                   input logic [APPROX_W-1:0] b);
    logic [APPROX_W:0]            r;
    logic [APPROX_W-APPROX_K-1:0] hi;
    r    = '0;
    r[0] = a[0] ^ b[0];
    for (int i = 1; i <= APPROX_K; i++) begin
      r[i] = a[i] ^ b[i] ^ (a[i-1] & b[i-1]);
    end
    hi = {1'b0, a[APPROX_W-1:APPROX_K+1]} + {1'b0, b[APPROX_W-1:APPROX_K+1]}
       + {{(APPROX_W-APPROX_K-1){1'b0}}, a[APPROX_K] & b[APPROX_K]};
    r[APPROX_W:APPROX_K+1] = hi;
    return r;
  endfunction

endpackage

// File: rtl/approx_sum_checker_if.sv
// Input (operands + approximate result) and output (exact result + error) streams
// of the approximate-sum checker.
interface approx_sum_checker_if #(
  parameter int W = approx_pkg::APPROX_W
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic [W:0]   in_approx;

  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out_exact;
  logic         out_err;
  logic [W:0]   out_ed;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_approx, out_ready,
    output in_ready, out_valid, out_exact, out_err, out_ed
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, in_approx, out_ready,
    input  in_ready, out_valid, out_exact, out_err, out_ed
  );

endinterface

// File: rtl/approx_stat_acc.sv
// Saturating error statistics, updated once per handed-off result; a clear
// takes priority over the update in the same cycle.
module approx_stat_acc #(
  parameter int W     = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             fire,
  input  logic             err,
  input  logic [W:0]       ed,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] errors,
  output logic [ACC_W-1:0] ed_sum,
  output logic [W:0]       ed_max
);

  // One spare bit above the wider operand catches the accumulator overflow.
  localparam int SUM_W = ((ACC_W > W + 1) ? ACC_W : W + 1) + 1;

  logic [SUM_W-1:0] ed_sum_next;

  assign ed_sum_next = SUM_W'(ed_sum) + SUM_W'(ed);

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samples <= '0;
      errors  <= '0;
      ed_sum  <= '0;
      ed_max  <= '0;
    end else if (clear) begin
      samples <= '0;
      errors  <= '0;
      ed_sum  <= '0;
      ed_max  <= '0;
    end else if (fire) begin
      if (samples != '1) samples <= samples + CNT_W'(1);
      if (err && (errors != '1)) errors <= errors + CNT_W'(1);
      ed_sum <= (ed_sum_next[SUM_W-1:ACC_W] != '0) ? '1 : ed_sum_next[ACC_W-1:0];
      if (ed > ed_max) ed_max <= ed;
    end
  end

endmodule

// File: rtl/approx_sum_checker.sv
// Two-stage streaming checker: recomputes the exact sum of each operand pair,
// flags and measures the approximate adder's error, and keeps statistics.
module approx_sum_checker
  import approx_pkg::*;
#(
  parameter int W     = APPROX_W,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  approx_sum_checker_if.slave  bus,
  input  logic                 stat_clear,
  output logic [CNT_W-1:0]     stat_samples,
  output logic [CNT_W-1:0]     stat_errors,
  output logic [ACC_W-1:0]     stat_ed_sum,
  output logic [W:0]           stat_ed_max
);

  logic         s1_valid;
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;
  logic         s1_cin;
  logic [W:0]   s1_approx;

  logic         s2_adv;
  logic         in_fire;
  logic         out_fire;
  logic [W:0]   exact;
  logic [W:0]   ed;

  assign s2_adv       = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_adv;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = bus.out_valid && bus.out_ready;

  // |exact - approx| always fits W+1 bits, so the sign picks the subtraction order.
  assign exact = {1'b0, s1_a} + {1'b0, s1_b} + {{W{1'b0}}, s1_cin};
  assign ed    = (exact < s1_approx) ? (s1_approx - exact) : (exact - s1_approx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // NOTE: the S1 payload has no reset; it is only ever consumed under s1_valid,
  // which is reset, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_a      <= bus.in_a;
      s1_b      <= bus.in_b;
      s1_cin    <= bus.in_cin;
      s1_approx <= bus.in_approx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_exact <= '0;
      bus.out_err   <= 1'b0;
      bus.out_ed    <= '0;
    end else if (s2_adv) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_exact <= exact;
        bus.out_err   <= (exact != s1_approx);
        bus.out_ed    <= ed;
      end
    end
  end

  approx_stat_acc #(
    .W     (W),
    .CNT_W (CNT_W),
    .ACC_W (ACC_W)
  ) u_stat (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (stat_clear),
    .fire    (out_fire),
    .err     (bus.out_err),
    .ed      (bus.out_ed),
    .samples (stat_samples),
    .errors  (stat_errors),
    .ed_sum  (stat_ed_sum),
    .ed_max  (stat_ed_max)
  );

endmodule

// File: tb/tb_approx_sum_checker.sv
// Bench for approx_sum_checker: directed literal cases plus randomized traffic
// against a queue-based reference model, on a full-width and a narrow-counter instance.
module tb_approx_sum_checker;
  import approx_pkg::*;

  localparam longint M_CNT_MAX = 64'hFFFF_FFFF;
  localparam longint M_ACC_MAX = 64'hFFFF_FFFF_FFFF;
  localparam longint S_CNT_MAX = 15;
  localparam longint S_ACC_MAX = 255;

  logic clk = 1'b0;
  logic rst_n;
  logic stat_clear;

  logic [31:0] m_samples, m_errors;
  logic [47:0] m_sum;
  logic [16:0] m_max;
  logic [3:0]  s_samples, s_errors;
  logic [7:0]  s_sum;
  logic [16:0] s_max;

  approx_sum_checker_if #(.W(16)) bus ();
  approx_sum_checker_if #(.W(16)) bus_s ();

  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.in_a      = bus.in_a;
  assign bus_s.in_b      = bus.in_b;
  assign bus_s.in_cin    = bus.in_cin;
  assign bus_s.in_approx = bus.in_approx;
  assign bus_s.out_ready = bus.out_ready;

  always #5 clk = ~clk;

  approx_sum_checker #(.W(16), .CNT_W(32), .ACC_W(48)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .stat_clear(stat_clear),
    .stat_samples(m_samples), .stat_errors(m_errors),
    .stat_ed_sum(m_sum), .stat_ed_max(m_max)
  );

  approx_sum_checker #(.W(16), .CNT_W(4), .ACC_W(8)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus_s), .stat_clear(stat_clear),
    .stat_samples(s_samples), .stat_errors(s_errors),
    .stat_ed_sum(s_sum), .stat_ed_max(s_max)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [16:0] exact;
    logic        err;
    logic [16:0] ed;
    int          t;
  } item_t;

  item_t  q[$];
  int     cyc;
  longint em_samples, em_errors, em_sum, es_samples, es_errors, es_sum, e_max;

  function automatic longint sat_add(input longint v, input longint inc, input longint maxv);
    return (v + inc > maxv) ? maxv : v + inc;
  endfunction

  function automatic item_t model_item(input logic [15:0] a, input logic [15:0] b,
                                       input logic cin, input logic [16:0] ap, input int t);
    item_t it;
    int    e, x;
    e  = int'(a) + int'(b) + int'(cin);
    x  = int'(ap);
    it.exact = 17'(e);
    it.err   = (e != x);
    it.ed    = 17'((e > x) ? e - x : x - e);
    it.t     = t;
    return it;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      cyc = 0;
      em_samples = 0; em_errors = 0; em_sum = 0;
      es_samples = 0; es_errors = 0; es_sum = 0; e_max = 0;
    end else begin
      bit ready_m, ov_m, ofire, ifire;
      ready_m = (q.size() < 2) || bus.out_ready;
      ov_m    = (q.size() > 0) && (cyc >= q[0].t + 1);
      ofire   = ov_m && bus.out_ready;
      ifire   = bus.in_valid && ready_m;
      cyc++;
      if (stat_clear) begin
        em_samples = 0; em_errors = 0; em_sum = 0;
        es_samples = 0; es_errors = 0; es_sum = 0; e_max = 0;
      end else if (ofire) begin
        em_samples = sat_add(em_samples, 1, M_CNT_MAX);
        es_samples = sat_add(es_samples, 1, S_CNT_MAX);
        em_errors  = sat_add(em_errors, longint'(q[0].err), M_CNT_MAX);
        es_errors  = sat_add(es_errors, longint'(q[0].err), S_CNT_MAX);
        em_sum     = sat_add(em_sum, longint'(q[0].ed), M_ACC_MAX);
        es_sum     = sat_add(es_sum, longint'(q[0].ed), S_ACC_MAX);
        if (longint'(q[0].ed) > e_max) e_max = longint'(q[0].ed);
      end
      if (ofire) void'(q.pop_front());
      if (ifire) q.push_back(model_item(bus.in_a, bus.in_b, bus.in_cin, bus.in_approx, cyc));
    end
  end

  // Compare process: every cycle out of reset, on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      bit exp_ov;
      exp_ov = (q.size() > 0) && (cyc >= q[0].t + 1);
      check("in_ready", bus.in_ready, (q.size() < 2) || bus.out_ready);
      check("out_valid", bus.out_valid, exp_ov);
      check("sat_out_valid", bus_s.out_valid, exp_ov);
      if (exp_ov) begin
        check("out_exact", bus.out_exact, q[0].exact);
        check("out_err", bus.out_err, q[0].err);
        check("out_ed", bus.out_ed, q[0].ed);
      end
      check("stat_samples", m_samples, em_samples);
      check("stat_errors", m_errors, em_errors);
      check("stat_ed_sum", m_sum, em_sum);
      check("stat_ed_max", m_max, e_max);
      check("sat_stat_samples", s_samples, es_samples);
      check("sat_stat_errors", s_errors, es_errors);
      check("sat_stat_ed_sum", s_sum, es_sum);
      check("sat_stat_ed_max", s_max, e_max);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic [16:0] ap);
    bit took;
    bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_approx = ap;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      took = bus.in_ready;
      @(posedge clk); #1;
      if (took) break;
      if (k == 199) check("send_timeout", 0, 1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [16:0] ap, input logic [16:0] ee,
                          input logic eerr, input logic [16:0] eed);
    send(a, b, cin, ap);
    check({name, "_not_yet_valid"}, bus.out_valid, 0);
    @(posedge clk); #1;
    check({name, "_valid"}, bus.out_valid, 1);
    check({name, "_exact"}, bus.out_exact, ee);
    check({name, "_err"}, bus.out_err, eerr);
    check({name, "_ed"}, bus.out_ed, eed);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_out_valid"}, bus.out_valid, 0);
    check({name, "_out_exact"}, bus.out_exact, 0);
    check({name, "_out_err"}, bus.out_err, 0);
    check({name, "_out_ed"}, bus.out_ed, 0);
    check({name, "_samples"}, m_samples, 0);
    check({name, "_errors"}, m_errors, 0);
    check({name, "_ed_sum"}, m_sum, 0);
    check({name, "_ed_max"}, m_max, 0);
    check({name, "_sat_out_valid"}, bus_s.out_valid, 0);
    check({name, "_sat_samples"}, s_samples, 0);
    check({name, "_in_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [16:0] held, seen[$];
    logic [16:0] exp_bp[3];
    int          idx, out_cyc[$], c;
    bit          took, have_held, stable;

    rst_n = 1'b0; stat_clear = 1'b0; bus.out_ready = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0; bus.in_approx = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // The adder model itself, pinned to hand-derived values.
    check("pin_approx_000f", approx_add(16'h000F, 16'h0001), 17'h0000C);
    check("pin_approx_ffff", approx_add(16'hFFFF, 16'h0001), 17'h0FFFC);
    check("pin_approx_1234", approx_add(16'h1234, 16'h0100), 17'h01334);
    check("pin_exact_ffff", exact_add(16'hFFFF, 16'h0001, 1'b0), 17'h10000);

    @(posedge clk); #1;
    directed("v1", 16'h1234, 16'h0100, 1'b0, 17'h01334, 17'h01334, 1'b0, 17'd0);
    @(posedge clk); #1;
    check("v1_samples", m_samples, 1);
    check("v1_errors", m_errors, 0);
    directed("v2", 16'h000F, 16'h0001, 1'b0, 17'h0000C, 17'h00010, 1'b1, 17'd4);
    directed("v3", 16'hFFFF, 16'h0001, 1'b0, 17'h0FFFC, 17'h10000, 1'b1, 17'd4);
    @(posedge clk); #1;
    check("v3_samples", m_samples, 3);
    check("v3_errors", m_errors, 2);
    check("v3_ed_sum", m_sum, 8);
    check("v3_ed_max", m_max, 4);
    directed("cin_pos", 16'h0000, 16'h0000, 1'b1, 17'h00000, 17'h00001, 1'b1, 17'd1);
    directed("cin_neg", 16'h0000, 16'h0000, 1'b1, 17'h00002, 17'h00001, 1'b1, 17'd1);
    @(posedge clk); #1;

    // Backpressure: three items offered with out_ready low for six cycles.
    for (int i = 0; i < 3; i++) exp_bp[i] = 17'(i * 'h111 + 1 + 2);
    bus.out_ready = 1'b0;
    idx = 0; have_held = 0; stable = 1; held = '0;
    bus.in_a = 16'h0001; bus.in_b = 16'h0002; bus.in_cin = 1'b0; bus.in_approx = exp_bp[0];
    bus.in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        if (!have_held) begin held = bus.out_exact; have_held = 1; end
        else if (bus.out_exact !== held) stable = 0;
      end
      @(posedge clk); #1;
      if (took) begin
        idx++;
        bus.in_a = 16'(idx * 'h111 + 1);
        bus.in_approx = (idx < 3) ? exp_bp[idx] : '0;
        if (idx >= 3) bus.in_valid = 1'b0;
      end
    end
    check("bp_accepted", idx, 2);
    check("bp_in_ready_low", bus.in_ready, 0);
    check("bp_held_stable", stable, 1);
    check("bp_held_value", held, exp_bp[0]);
    bus.out_ready = 1'b1;
    c = 0;
    while (seen.size() < 3 && c < 20) begin
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        seen.push_back(bus.out_exact);
        out_cyc.push_back(c);
      end
      @(posedge clk); #1;
      c++;
      if (took) begin idx++; bus.in_valid = 1'b0; end
    end
    check("bp_drained", seen.size(), 3);
    for (int i = 0; i < seen.size(); i++) check("bp_order", seen[i], exp_bp[i]);
    if (seen.size() == 3) check("bp_back_to_back", out_cyc[2] - out_cyc[0], 2);

    // stat_clear coinciding with delivery of an erroneous result.
    send(16'h0000, 16'h0000, 1'b1, 17'h00000);
    @(posedge clk); #1;
    check("clr_result_present", bus.out_valid && bus.out_err, 1);
    stat_clear = 1'b1;
    @(posedge clk); #1;
    stat_clear = 1'b0;
    check("clr_delivered", bus.out_valid, 0);
    check("clr_samples", m_samples, 0);
    check("clr_errors", m_errors, 0);
    check("clr_ed_sum", m_sum, 0);
    check("clr_ed_max", m_max, 0);
    check("clr_sat_samples", s_samples, 0);

    // Twenty erroneous results of distance 255 saturate the narrow instance.
    bus.in_a = 16'h00FF; bus.in_b = 16'h0000; bus.in_cin = 1'b0; bus.in_approx = '0;
    bus.in_valid = 1'b1;
    idx = 0;
    for (int k = 0; k < 100 && idx < 20; k++) begin
      @(negedge clk);
      took = bus.in_ready;
      @(posedge clk); #1;
      if (took) idx++;
      bus.in_valid = (idx < 20);
    end
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("sat_samples_15", s_samples, 15);
    check("sat_errors_15", s_errors, 15);
    check("sat_ed_sum_255", s_sum, 255);
    check("sat_ed_max_255", s_max, 255);
    check("full_samples_20", m_samples, 20);
    check("full_errors_20", m_errors, 20);
    check("full_ed_sum_5100", m_sum, 5100);

    // Randomized traffic with a mid-stream reset.
    took = 0;
    for (int it = 0; it < 400; it++) begin
      bus.out_ready = ($urandom % 4) != 0;
      stat_clear    = ($urandom % 40) == 0;
      if (!(bus.in_valid && !took)) begin
        bus.in_valid = ($urandom % 4) != 0;
        bus.in_a     = 16'($urandom);
        bus.in_b     = 16'($urandom);
        bus.in_cin   = 1'($urandom);
        case ($urandom % 3)
          0:       bus.in_approx = exact_add(bus.in_a, bus.in_b, bus.in_cin);
          1:       bus.in_approx = approx_add(bus.in_a, bus.in_b);
          default: bus.in_approx = 17'($urandom);
        endcase
      end
      if (it == 200) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b0; stat_clear = 1'b0; bus.out_ready = 1'b1; took = 0;
        directed("post_reset", 16'h0010, 16'h0020, 1'b0, 17'h00031, 17'h00030, 1'b1, 17'd1);
        continue;
      end
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; stat_clear = 1'b0; bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("final_drained", bus.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
